// File: rtl/max_rr_sched_pkg.sv
// Shared widths and helpers for the round-robin max scheduler.
package max_rr_sched_pkg;

    localparam int W_DEF = 8;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] max_u(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_rr_sched_arb.sv
// Round-robin arbiter: first eligible requester at or after ptr wins.
module rr_arbiter
    import max_rr_sched_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDW = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);

    logic [IDW-1:0] j;

    // Scan farthest-first so the nearest eligible slot overwrites the rest.
    always_comb begin
        grant = '0;
        gidx  = '0;
        j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (eligible[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = j;
            end
        end
    end

endmodule

// File: rtl/max_rr_sched.sv
// Shares one max comparator among NREQ framed sample streams.
module max_rr_sched
    import max_rr_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W = W_DEF,
    localparam int IDW = idw_of(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id
);

    logic [W-1:0]    acc [NREQ];
    logic [NREQ-1:0] acc_vld;
    logic [IDW-1:0]  ptr;
    logic            slot_free;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic [W-1:0]    gdata;
    logic [W-1:0]    nmax;
    logic            glast;

    // A last sample needs the result slot; non-last samples never do.
    assign slot_free = !res_valid || res_ready;
    assign eligible  = req_valid & (~req_last | {NREQ{slot_free}});

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .eligible(eligible),
        .ptr     (ptr),
        .grant   (grant),
        .gidx    (gidx)
    );

    assign req_ready = grant;
    assign gdata     = req_data[int'(gidx)*W +: W];
    assign glast     = req_last[gidx];
    assign nmax      = acc_vld[gidx]
                     ? W'(max_u(32'(acc[gidx]), 32'(gdata)))
                     : gdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ptr       <= '0;
            acc_vld   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (|grant) begin
                ptr <= IDW'((int'(gidx) + 1) % NREQ);
                if (glast) begin
                    res_valid     <= 1'b1;
                    res_data      <= nmax;
                    res_id        <= gidx;
                    acc[gidx]     <= '0;
                    acc_vld[gidx] <= 1'b0;
                end else begin
                    acc[gidx]     <= nmax;
                    acc_vld[gidx] <= 1'b1;
                end
            end
        end
    end

endmodule
